matmul_seq_ctrl: RTL

//  Parametrised sequencer for the DIMxDIM matrix-multiply datapath. Replaces the hard-wired S0..S12 chain.
//  - Loads DIM*DIM operand words; steps the MAC through C[i][j] = sum_k A[i][k]*B[k][j].
//  - Writes each result element through a ready handshake, then pulses done.
//  - Controls operand registers, operand muxes, MAC clear/enable and the result store; no datapath inside.

---
 rtl/matmul_pkg.sv | 23 ++
 rtl/matmul_seq_ctrl_if.sv | 32 +++
 rtl/matmul_idx_cnt.sv | 49 ++++
 rtl/matmul_seq_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply datapath blocks.
// Holds the sequencer state encoding, a constant clog2 and the default dimension.
package matmul_pkg;

    localparam int DIM_DEFAULT = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Control bundle between the matmul sequencer (slave) and its host/datapath (master).
// Master drives start, operand-valid and result-ready; slave drives all datapath controls.
interface matmul_seq_ctrl_if #(
    parameter int DIM = matmul_pkg::DIM_DEFAULT
);
    localparam int AW = matmul_pkg::clog2(DIM * DIM);

    logic          cf_load;
    logic          in_valid;
    logic          res_ready;
    logic          busy;
    logic          reg_ld;
    logic [AW-1:0] ld_addr;
    logic [AW-1:0] a_sel;
    logic [AW-1:0] b_sel;
    logic          mac_en;
    logic          mac_clr;
    logic          res_wr;
    logic [AW-1:0] res_addr;
    logic          done;

    modport master (
        output cf_load, in_valid, res_ready,
        input  busy, reg_ld, ld_addr, a_sel, b_sel, mac_en, mac_clr, res_wr, res_addr, done
    );

    modport slave (
        input  cf_load, in_valid, res_ready,
        output busy, reg_ld, ld_addr, a_sel, b_sel, mac_en, mac_clr, res_wr, res_addr, done
    );

endinterface

// File: rtl/matmul_idx_cnt.sv
// Nested i/j/k element counter: k steps inside an element, (i,j) step row-major between elements.
// Updates one cycle after a step/clear request; both k and (i,j) wrap to zero past their last value.
module matmul_idx_cnt
    import matmul_pkg::*;
#(
    parameter int DIM = DIM_DEFAULT,
    parameter int IW  = clog2(DIM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          k_clr,
    input  logic          k_step,
    input  logic          ij_step,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic [IW-1:0] k,
    output logic          k_last,
    output logic          ij_last
);

    localparam logic [IW-1:0] LAST = IW'(DIM - 1);

    assign k_last  = (k == LAST);
    assign ij_last = (i == LAST) && (j == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else begin
            if (k_clr || (k_step && k_last)) begin
                k <= '0;
            end else if (k_step) begin
                k <= k + 1'b1;
            end
            // Stepping past the last element returns to (0,0), ready for the next product.
            if (ij_step) begin
                if (j == LAST) begin
                    j <= '0;
                    i <= (i == LAST) ? '0 : i + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the DIMxDIM matmul: load DIM*DIM operand pairs, run DIM MACs + MAC_LAT drain per element, store.
// Load stalls while in_valid is low; each result is held on res_wr/res_addr until res_ready accepts it.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int DIM     = DIM_DEFAULT,
    parameter int MAC_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    matmul_seq_ctrl_if.slave bus
);

    localparam int AW = clog2(DIM * DIM);
    localparam int IW = clog2(DIM);
    localparam int DW = (MAC_LAT > 1) ? clog2(MAC_LAT) : 1;

    localparam logic [AW-1:0] DIM_A      = AW'(DIM);
    localparam logic [AW-1:0] LD_LAST    = AW'(DIM * DIM - 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(MAC_LAT - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] ld_idx, ld_idx_nxt;
    logic [DW-1:0] drain, drain_nxt;

    logic [IW-1:0] i, j, k;
    logic          k_clr, k_step, ij_step, k_last, ij_last;

    matmul_idx_cnt #(.DIM(DIM), .IW(IW)) u_idx (
        .clk     (clk),
        .reset   (reset),
        .k_clr   (k_clr),
        .k_step  (k_step),
        .ij_step (ij_step),
        .i       (i),
        .j       (j),
        .k       (k),
        .k_last  (k_last),
        .ij_last (ij_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            ld_idx <= '0;
            drain  <= '0;
        end else begin
            state  <= state_nxt;
            ld_idx <= ld_idx_nxt;
            drain  <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ld_idx_nxt   = ld_idx;
        drain_nxt    = drain;
        k_clr        = 1'b0;
        k_step       = 1'b0;
        ij_step      = 1'b0;
        bus.busy     = (state != ST_IDLE);
        bus.reg_ld   = 1'b0;
        bus.ld_addr  = '0;
        bus.a_sel    = '0;
        bus.b_sel    = '0;
        bus.mac_en   = 1'b0;
        bus.mac_clr  = 1'b0;
        bus.res_wr   = 1'b0;
        bus.res_addr = '0;
        bus.done     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (bus.cf_load) begin
                    state_nxt  = ST_LOAD;
                    ld_idx_nxt = '0;
                end
            end
            ST_LOAD: begin
                bus.reg_ld  = bus.in_valid;
                bus.ld_addr = ld_idx;
                if (bus.in_valid) begin
                    if (ld_idx == LD_LAST) begin
                        state_nxt  = ST_COMPUTE;
                        ld_idx_nxt = '0;
                        k_clr      = 1'b1;
                    end else begin
                        ld_idx_nxt = ld_idx + 1'b1;
                    end
                end
            end
            ST_COMPUTE: begin
                bus.mac_en  = 1'b1;
                bus.mac_clr = (k == '0);
                bus.a_sel   = AW'(i) * DIM_A + AW'(k);
                bus.b_sel   = AW'(k) * DIM_A + AW'(j);
                k_step      = 1'b1;
                if (k_last) begin
                    state_nxt = ST_DRAIN;
                    drain_nxt = DRAIN_INIT;
                end
            end
            ST_DRAIN: begin
                if (drain == '0) begin
                    state_nxt = ST_WRITE;
                end else begin
                    drain_nxt = drain - 1'b1;
                end
            end
            ST_WRITE: begin
                bus.res_wr   = 1'b1;
                bus.res_addr = AW'(i) * DIM_A + AW'(j);
                if (bus.res_ready) begin
                    ij_step   = 1'b1;
                    k_clr     = 1'b1;
                    state_nxt = ij_last ? ST_DONE : ST_COMPUTE;
                end
            end
            ST_DONE: begin
                bus.done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
